// File: rtl/timer_pkg.sv
// Shared register map offsets and CTRL field layout for the timer array.
package timer_pkg;

  localparam int COUNT_OFS   = 0;
  localparam int LIMIT_OFS   = 4;
  localparam int CH_STRIDE   = 8;
  localparam int CTRL_STRIDE = 4;

  localparam int READY_BIT   = 0;
  localparam int OVR_BIT     = 2;
  localparam int EN_BIT      = 4;
  localparam int ONESHOT_BIT = 5;
  localparam int IE_BIT      = 8;

  // Channels come out of reset enabled, everything else clear.
  localparam logic [8:0] CTRL_RESET = 9'h010;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: COUNT/LIMIT/CTRL state and the wrap decision.
module timer_channel
  import timer_pkg::*;
#(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tick,
  input  logic            countWe,
  input  logic            limitWe,
  input  logic            ctrlWe,
  input  logic [BITS-1:0] wrData,
  output logic [BITS-1:0] count,
  output logic [BITS-1:0] limit,
  output logic [BITS-1:0] ctrl,
  output logic            irqReq
);

  logic ready;
  logic ovr;
  logic en;
  logic oneShot;
  logic ie;
  logic wrap;

  // LIMIT=0 means free-run; the nonzero guard also keeps LIMIT-1 from underflowing.
  assign wrap = tick && en && (limit != '0) && (count >= limit - BITS'(1));

  // COUNT: a bus write takes priority over the tick increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (countWe) begin
      count <= wrData;
    end else if (tick && en) begin
      count <= wrap ? '0 : count + BITS'(1);
    end
  end

  // LIMIT: plain register, changing it never disturbs COUNT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      limit <= '0;
    end else if (limitWe) begin
      limit <= wrData;
    end
  end

  // CTRL flags: READY/OVR are sticky with write-0-to-clear, and a wrap set beats a clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready   <= CTRL_RESET[READY_BIT];
      ovr     <= CTRL_RESET[OVR_BIT];
      en      <= CTRL_RESET[EN_BIT];
      oneShot <= CTRL_RESET[ONESHOT_BIT];
      ie      <= CTRL_RESET[IE_BIT];
    end else begin
      if (wrap) begin
        ready <= 1'b1;
      end else if (ctrlWe && !wrData[READY_BIT]) begin
        ready <= 1'b0;
      end
      // OVR looks at READY as it was before this edge, not at a coincident clear.
      if (wrap && ready) begin
        ovr <= 1'b1;
      end else if (ctrlWe && !wrData[OVR_BIT]) begin
        ovr <= 1'b0;
      end
      if (ctrlWe) begin
        en      <= wrData[EN_BIT];
        oneShot <= wrData[ONESHOT_BIT];
        ie      <= wrData[IE_BIT];
      end else if (wrap && oneShot) begin
        en <= 1'b0;
      end
    end
  end

  // Assemble the CTRL read view; unused bits read as zero.
  always_comb begin
    ctrl              = '0;
    ctrl[READY_BIT]   = ready;
    ctrl[OVR_BIT]     = ovr;
    ctrl[EN_BIT]      = en;
    ctrl[ONESHOT_BIT] = oneShot;
    ctrl[IE_BIT]      = ie;
  end

  assign irqReq = ready & ie;

endmodule

// File: rtl/mm_timer_array.sv
// Memory-mapped timer array: shared prescaler, address decode, read mux and irq.
module mm_timer_array
  import timer_pkg::*;
#(
  parameter int              BITS        = 32,
  parameter int              NUM_CH      = 4,
  parameter logic [BITS-1:0] BASE        = 32'hF0000020,
  parameter logic [BITS-1:0] CTRL_BASE   = 32'hF0000120,
  parameter int              TICK_CYCLES = 65000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic            re,
  input  logic [BITS-1:0] memAddr,
  input  logic [BITS-1:0] dataBusIn,
  output logic [BITS-1:0] dataBusOut,
  output logic            irq
);

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  logic [PW-1:0]   prescale;
  logic            tick;
  logic [BITS-1:0] countQ [NUM_CH];
  logic [BITS-1:0] limitQ [NUM_CH];
  logic [BITS-1:0] ctrlQ  [NUM_CH];
  logic [NUM_CH-1:0] countHit;
  logic [NUM_CH-1:0] limitHit;
  logic [NUM_CH-1:0] ctrlHit;
  logic [NUM_CH-1:0] irqReq;
  logic [BITS-1:0] rdData;

  // With TICK_CYCLES=1 the compare is always true, giving a tick every cycle.
  assign tick = (prescale == PW'(TICK_CYCLES - 1));

  // Free-running prescaler, wraps on the tick cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescale <= '0;
    end else begin
      prescale <= tick ? '0 : prescale + PW'(1);
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : gCh
    assign countHit[ch] = (memAddr == BASE + BITS'(ch * CH_STRIDE + COUNT_OFS));
    assign limitHit[ch] = (memAddr == BASE + BITS'(ch * CH_STRIDE + LIMIT_OFS));
    assign ctrlHit[ch]  = (memAddr == CTRL_BASE + BITS'(ch * CTRL_STRIDE));

    timer_channel #(
      .BITS(BITS)
    ) uChannel (
      .clk    (clk),
      .reset  (reset),
      .tick   (tick),
      .countWe(we && countHit[ch]),
      .limitWe(we && limitHit[ch]),
      .ctrlWe (we && ctrlHit[ch]),
      .wrData (dataBusIn),
      .count  (countQ[ch]),
      .limit  (limitQ[ch]),
      .ctrl   (ctrlQ[ch]),
      .irqReq (irqReq[ch])
    );
  end

  // Read mux: at most one hit is active, OR keeps the bus idle at zero otherwise.
  always_comb begin
    rdData = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (countHit[i]) rdData = rdData | countQ[i];
      if (limitHit[i]) rdData = rdData | limitQ[i];
      if (ctrlHit[i])  rdData = rdData | ctrlQ[i];
    end
    dataBusOut = re ? rdData : '0;
  end

  assign irq = |irqReq;

endmodule

// File: tb/tb_mm_timer_array.sv
// Directed scenarios plus a randomized bus phase checked against a register-level model.
module tb_mm_timer_array;

  localparam int TC  = 4;
  localparam int NCH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic        re;
  logic [31:0] memAddr;
  logic [31:0] dataBusIn;
  logic [31:0] dataBusOut;
  logic        irq;

  int total = 0;
  int bad   = 0;

  // Reference state: one entry per channel, plus the prescaler phase.
  logic [31:0] mCount [NCH];
  logic [31:0] mLimit [NCH];
  logic [NCH-1:0] mReady, mOvr, mEn, mOne, mIe;
  int  mPre;
  bit  lastTick;
  logic [31:0] v;

  mm_timer_array #(
    .BITS(32), .NUM_CH(NCH), .BASE(32'hF0000020), .CTRL_BASE(32'hF0000120), .TICK_CYCLES(TC)
  ) dut (
    .clk(clk), .reset(reset), .we(we), .re(re), .memAddr(memAddr),
    .dataBusIn(dataBusIn), .dataBusOut(dataBusOut), .irq(irq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] cntA(int c); return 32'hF0000020 + 32'(8 * c); endfunction
  function automatic logic [31:0] limA(int c); return 32'hF0000024 + 32'(8 * c); endfunction
  function automatic logic [31:0] ctlA(int c); return 32'hF0000120 + 32'(4 * c); endfunction

  function automatic logic [31:0] ctrlVal(int c);
    logic [31:0] r;
    r = '0;
    r[0] = mReady[c]; r[2] = mOvr[c]; r[4] = mEn[c]; r[5] = mOne[c]; r[8] = mIe[c];
    return r;
  endfunction

  function automatic logic [31:0] modelRead(logic [31:0] a);
    for (int c = 0; c < NCH; c++) begin
      if (a == cntA(c)) return mCount[c];
      if (a == limA(c)) return mLimit[c];
      if (a == ctlA(c)) return ctrlVal(c);
    end
    return 32'h0;
  endfunction

  function automatic logic modelIrq();
    return |(mReady & mIe);
  endfunction

  task automatic modelReset();
    for (int c = 0; c < NCH; c++) begin
      mCount[c] = '0;
      mLimit[c] = '0;
    end
    mReady = '0; mOvr = '0; mEn = '1; mOne = '0; mIe = '0;
    mPre = 0;
  endtask

  // Advance the model by one clock edge using the bus inputs present at that edge.
  task automatic modelStep();
    bit tk, wrapC, oldReady;
    tk = (mPre == TC - 1);
    mPre = tk ? 0 : mPre + 1;
    lastTick = tk;
    for (int c = 0; c < NCH; c++) begin
      wrapC = tk && mEn[c] && (mLimit[c] != 0) && (mCount[c] >= mLimit[c] - 32'd1);
      oldReady = mReady[c];
      if (we && memAddr == cntA(c)) mCount[c] = dataBusIn;
      else if (tk && mEn[c]) mCount[c] = wrapC ? 32'd0 : mCount[c] + 32'd1;
      if (we && memAddr == limA(c)) mLimit[c] = dataBusIn;
      if (we && memAddr == ctlA(c)) begin
        if (!dataBusIn[0]) mReady[c] = 1'b0;
        if (!dataBusIn[2]) mOvr[c] = 1'b0;
        mEn[c]  = dataBusIn[4];
        mOne[c] = dataBusIn[5];
        mIe[c]  = dataBusIn[8];
      end else if (wrapC && mOne[c]) begin
        mEn[c] = 1'b0;
      end
      if (wrapC) begin
        mReady[c] = 1'b1;
        if (oldReady) mOvr[c] = 1'b1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic waitTick();
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!lastTick && n < TC + 1);
  endtask

  task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
    memAddr = a; dataBusIn = d; we = 1'b1;
    cycle();
    we = 1'b0;
  endtask

  task automatic busRead(input logic [31:0] a, input string tag, output logic [31:0] val);
    memAddr = a; re = 1'b1;
    #1;
    val = dataBusOut;
    chk(tag, dataBusOut, modelRead(a));
    re = 1'b0;
  endtask

  task automatic chkIrq(input string tag);
    chk(tag, {31'b0, irq}, {31'b0, modelIrq()});
  endtask

  task automatic checkResetState(input string tag);
    for (int c = 0; c < NCH; c++) begin
      busRead(cntA(c), {tag, "_count"}, v); chk({tag, "_count_c"}, v, 32'h0);
      busRead(limA(c), {tag, "_limit"}, v); chk({tag, "_limit_c"}, v, 32'h0);
      busRead(ctlA(c), {tag, "_ctrl"}, v);  chk({tag, "_ctrl_c"}, v, 32'h10);
    end
    chk({tag, "_irq"}, {31'b0, irq}, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; we = 1'b0; re = 1'b0; memAddr = '0; dataBusIn = '0;
    modelReset();
    #2;
    // 1: reset state
    checkResetState("t1");
    memAddr = cntA(0); re = 1'b0; #1;
    chk("t1_idle_bus", dataBusOut, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    modelReset();

    // 2: ch0 LIMIT=3 with IE, count sequence and READY/irq
    waitTick();
    busWrite(limA(0), 32'd3);
    busWrite(ctlA(0), 32'h110);
    busWrite(cntA(0), 32'd0);
    busRead(cntA(0), "t2_c0", v); chk("t2_c0_c", v, 32'd0);
    waitTick(); busRead(cntA(0), "t2_c1", v); chk("t2_c1_c", v, 32'd1);
    waitTick(); busRead(cntA(0), "t2_c2", v); chk("t2_c2_c", v, 32'd2);
    waitTick(); busRead(cntA(0), "t2_c3", v); chk("t2_c3_c", v, 32'd0);
    busRead(ctlA(0), "t2_ctrl", v); chk("t2_ctrl_c", v, 32'h111);
    chk("t2_irq_on", {31'b0, irq}, 32'h1);
    busWrite(ctlA(0), 32'h110);
    busRead(ctlA(0), "t2_clr", v); chk("t2_clr_c", v, 32'h110);
    chk("t2_irq_off", {31'b0, irq}, 32'h0);

    // 3: ch1 overrun
    waitTick();
    busWrite(limA(1), 32'd2);
    busWrite(cntA(1), 32'd0);
    repeat (4) waitTick();
    busRead(ctlA(1), "t3_ovr", v); chk("t3_ovr_c", v, 32'h15);
    busWrite(ctlA(1), 32'h10);
    busRead(ctlA(1), "t3_clr", v); chk("t3_clr_c", v, 32'h10);
    chkIrq("t3_irq");

    // 4: ch2 one-shot
    waitTick();
    busWrite(ctlA(2), 32'h30);
    busWrite(limA(2), 32'd5);
    busWrite(cntA(2), 32'd0);
    repeat (5) waitTick();
    busRead(cntA(2), "t4_cnt", v); chk("t4_cnt_c", v, 32'd0);
    busRead(ctlA(2), "t4_ctrl", v); chk("t4_ctrl_c", v, 32'h21);
    repeat (20) waitTick();
    busRead(cntA(2), "t4_hold", v); chk("t4_hold_c", v, 32'd0);

    // 5: COUNT write on a tick cycle, free-run wrap at 2^32
    waitTick();
    repeat (TC - 1) cycle();
    busWrite(cntA(3), 32'd7);
    busRead(cntA(3), "t5_wr7", v); chk("t5_wr7_c", v, 32'd7);
    busWrite(cntA(3), 32'hFFFF_FFFF);
    busRead(cntA(3), "t5_max", v); chk("t5_max_c", v, 32'hFFFF_FFFF);
    waitTick();
    busRead(cntA(3), "t5_wrap", v); chk("t5_wrap_c", v, 32'd0);
    busRead(ctlA(3), "t5_ctrl", v); chk("t5_ctrl_c", v, 32'h10);

    // 6: wrap coincident with a READY-clearing CTRL write
    waitTick();
    busWrite(ctlA(0), 32'h110);
    busWrite(cntA(0), 32'd2);
    cycle();
    busWrite(ctlA(0), 32'h110);
    busRead(ctlA(0), "t6_ctrl", v); chk("t6_ctrl_c", v, 32'h111);
    busRead(cntA(0), "t6_cnt", v); chk("t6_cnt_c", v, 32'd0);
    chk("t6_irq", {31'b0, irq}, 32'h1);

    // 6b: reset mid-count
    cycle(); cycle();
    #1;
    reset = 1'b1;
    #1;
    modelReset();
    checkResetState("t6r");
    @(negedge clk);
    reset = 1'b0;
    modelReset();
    waitTick();
    busRead(cntA(0), "t6r_resume", v); chk("t6r_resume_c", v, 32'd1);

    // Randomized bus traffic against the model
    for (int it = 0; it < 600; it++) begin
      int op, ch;
      logic [31:0] a;
      op = $urandom_range(0, 9);
      ch = $urandom_range(0, NCH - 1);
      case (op)
        0: busWrite(cntA(ch), ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 7)));
        1: busWrite(limA(ch), 32'($urandom_range(0, 6)));
        2: busWrite(ctlA(ch), $urandom | 32'h10);
        3: busWrite(ctlA(ch), $urandom);
        4: begin
          case ($urandom_range(0, 2))
            0: a = 32'hF0000040;
            1: a = 32'hF0000130;
            default: a = $urandom & 32'hFFFF_FFFC;
          endcase
          busWrite(a, $urandom);
        end
        5, 6, 7: begin
          case ($urandom_range(0, 2))
            0: a = cntA(ch);
            1: a = limA(ch);
            default: a = ctlA(ch);
          endcase
          busRead(a, "rnd_read", v);
          cycle();
        end
        8: begin
          a = ($urandom_range(0, 1) == 0) ? 32'hF0000040 : 32'hF0000000 + 32'($urandom_range(0, 63) * 4);
          busRead(a, "rnd_unmapped", v);
          cycle();
        end
        default: cycle();
      endcase
      chkIrq("rnd_irq");
    end
    for (int c = 0; c < NCH; c++) begin
      busRead(ctlA(c), "end_ctrl", v);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
